// File: rtl/apb_master_mux.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// apb_master_mux
//   APB4 master for N slaves. It takes one request per IN_VALID/IN_READY
//   handshake, decodes the target slave from the top address bits, runs the
//   SETUP/ACCESS sequence and returns a one-cycle response pulse.
//   Back-to-back requests go straight from ACCESS to SETUP with no idle cycle.
//
// Optional feature macro: APB_TIMEOUT_EN
//   When defined, the master aborts an ACCESS phase after TIMEOUT_CYCLES
//   consecutive wait cycles and reports an error response.
//
// Ports
//   PCLK, PRESET          clock, asynchronous active-high reset
//   IN_VALID/IN_READY     request handshake
//   IN_ADDR/WRITE/DATA/STRB   request payload
//   OUT_VALID             one-cycle response pulse
//   OUT_RDATA/OUT_SLVERR  response payload (RDATA is 0 for writes and errors)
//   PADDR..PSTRB          APB request signals, PSEL is one-hot
//   PRDATA/PREADY/PSLVERR per-slave APB response signals
// -----------------------------------------------------------------------------
module apb_master_mux #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int SLAVES_NUM     = 4,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic                             IN_VALID,
    output logic                             IN_READY,
    input  logic [ADDRESS_WIDTH-1:0]         IN_ADDR,
    input  logic                             IN_WRITE,
    input  logic [DATA_WIDTH-1:0]            IN_DATA,
    input  logic [STRB_WIDTH-1:0]            IN_STRB,
    output logic                             OUT_VALID,
    output logic [DATA_WIDTH-1:0]            OUT_RDATA,
    output logic                             OUT_SLVERR,
    output logic [ADDRESS_WIDTH-1:0]         PADDR,
    output logic [SLAVES_NUM-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [STRB_WIDTH-1:0]            PSTRB,
    input  logic [SLAVES_NUM*DATA_WIDTH-1:0] PRDATA,
    input  logic [SLAVES_NUM-1:0]            PREADY,
    input  logic [SLAVES_NUM-1:0]            PSLVERR
);

    localparam int SEL_BITS = (SLAVES_NUM > 1) ? $clog2(SLAVES_NUM) : 1;
    localparam logic [SEL_BITS:0] SLV_LIM = (SEL_BITS + 1)'(SLAVES_NUM);

    // Elaboration-time parameter sanity checks.
    if ((DATA_WIDTH % 8) != 0 || SLAVES_NUM < 1 || SLAVES_NUM > 16 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("apb_master_mux: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]  paddr_q, paddr_d;
    logic [SLAVES_NUM-1:0]     psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]     pstrb_q, pstrb_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]     out_rdata_q, out_rdata_d;
    logic                      out_slverr_q, out_slverr_d;
    // A request to an unmapped slave accepted on a completing edge cannot
    // share that edge's response pulse, so its error pulse is deferred.
    logic                      pend_err_q, pend_err_d;

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_d;
`endif

    // ---------------- request decode ----------------
    logic [SEL_BITS-1:0]       req_idx;
    logic                      req_hit;
    logic [SLAVES_NUM-1:0]     req_onehot;

    assign req_idx = IN_ADDR[ADDRESS_WIDTH-1 -: SEL_BITS];
    assign req_hit = ({1'b0, req_idx} < SLV_LIM);

    for (genvar gi = 0; gi < SLAVES_NUM; gi++) begin : g_onehot
        assign req_onehot[gi] = (req_idx == SEL_BITS'(gi));
    end

    // ---------------- response mux (AND-OR on the one-hot PSEL) ----------------
    logic                      sel_ready;
    logic                      sel_slverr;
    logic [DATA_WIDTH-1:0]     rdata_or [SLAVES_NUM+1];
    logic [DATA_WIDTH-1:0]     sel_rdata;

    assign sel_ready  = |(PREADY  & psel_q);
    assign sel_slverr = |(PSLVERR & psel_q);
    assign rdata_or[0] = '0;

    for (genvar gi = 0; gi < SLAVES_NUM; gi++) begin : g_rdata_mux
        assign rdata_or[gi+1] = rdata_or[gi] |
            ({DATA_WIDTH{psel_q[gi]}} & PRDATA[gi*DATA_WIDTH +: DATA_WIDTH]);
    end
    assign sel_rdata = rdata_or[SLAVES_NUM];

    // ---------------- next-state / output logic ----------------
    logic in_ready;
    logic load_req;

    always_comb begin
        state_d      = state_q;
        paddr_d      = paddr_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        out_valid_d  = 1'b0;
        out_rdata_d  = '0;
        out_slverr_d = 1'b0;
        pend_err_d   = 1'b0;
        in_ready     = 1'b0;
        load_req     = 1'b0;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                in_ready = ~pend_err_q;
                if (pend_err_q) begin
                    out_valid_d  = 1'b1;
                    out_slverr_d = 1'b1;
                end else if (IN_VALID) begin
                    if (req_hit) begin
                        load_req = 1'b1;
                    end else begin
                        out_valid_d  = 1'b1;
                        out_slverr_d = 1'b1;
                    end
                end
            end

            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end

            ST_ACCESS: begin
                in_ready = sel_ready;
                if (sel_ready) begin
                    out_valid_d  = 1'b1;
                    out_slverr_d = sel_slverr;
                    out_rdata_d  = (pwrite_q || sel_slverr) ? '0 : sel_rdata;
                    penable_d    = 1'b0;
                    if (IN_VALID && req_hit) begin
                        load_req = 1'b1;
                    end else begin
                        pend_err_d = IN_VALID;
                        state_d    = ST_IDLE;
                        psel_d     = '0;
                        pstrb_d    = '0;
                    end
                end else begin
`ifdef APB_TIMEOUT_EN
                    if (tmo_cnt_q == TMO_LAST) begin
                        out_valid_d  = 1'b1;
                        out_slverr_d = 1'b1;
                        penable_d    = 1'b0;
                        psel_d       = '0;
                        pstrb_d      = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Shared request capture for both the IDLE and back-to-back paths.
        if (load_req) begin
            paddr_d   = IN_ADDR;
            pwrite_d  = IN_WRITE;
            pwdata_d  = IN_DATA;
            pstrb_d   = IN_WRITE ? IN_STRB : '0;
            psel_d    = req_onehot;
            penable_d = 1'b0;
            state_d   = ST_SETUP;
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q      <= ST_IDLE;
            paddr_q      <= '0;
            psel_q       <= '0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            out_valid_q  <= 1'b0;
            out_rdata_q  <= '0;
            out_slverr_q <= 1'b0;
            pend_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            paddr_q      <= paddr_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            out_valid_q  <= out_valid_d;
            out_rdata_q  <= out_rdata_d;
            out_slverr_q <= out_slverr_d;
            pend_err_q   <= pend_err_d;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign IN_READY   = in_ready;
    assign OUT_VALID  = out_valid_q;
    assign OUT_RDATA  = out_rdata_q;
    assign OUT_SLVERR = out_slverr_q;
    assign PADDR      = paddr_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PWDATA     = pwdata_q;
    assign PSTRB      = pstrb_q;

endmodule
